// File: rtl/spdif_transmitter_pkg.sv
// rtl/spdif_transmitter_pkg.sv - shared S/PDIF framing constants and preamble lookup
package audipus_pkg;

    localparam int SLOTS_PER_SUB    = 32;
    localparam int FRAMES_PER_BLOCK = 192;
    localparam int HALF_PER_FRAME   = 4 * SLOTS_PER_SUB;

    // Preamble half-cells, first half-cell in the MSB, for a line level of 0 before the preamble
    localparam logic [7:0] PRE_B = 8'b1110_1000;
    localparam logic [7:0] PRE_M = 8'b1110_0010;
    localparam logic [7:0] PRE_W = 8'b1110_0100;

    typedef enum logic [1:0] {
        PRE_SEL_B,
        PRE_SEL_M,
        PRE_SEL_W
    } pre_sel_t;

    function automatic logic [7:0] pre_pattern(input pre_sel_t sel);
        case (sel)
            PRE_SEL_B: return PRE_B;
            PRE_SEL_M: return PRE_M;
            default:   return PRE_W;
        endcase
    endfunction

endpackage

// File: rtl/spdif_transmitter_if.sv
// rtl/spdif_transmitter_if.sv - left/right sample pair handshake into the transmitter
interface spdif_transmitter_if #(
    parameter int SAMPLE_W = 24
);
    logic [SAMPLE_W-1:0] sample_l;
    logic [SAMPLE_W-1:0] sample_r;
    logic                sample_valid;
    logic                sample_ready;

    modport master (output sample_l, sample_r, sample_valid, input sample_ready);
    modport slave  (input sample_l, sample_r, sample_valid, output sample_ready);
endinterface

// File: rtl/spdif_bmc_cell.sv
// rtl/spdif_bmc_cell.sv - half-cell biphase-mark / preamble serializer holding the line level
module spdif_bmc_cell
    import audipus_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_tick,
    input  logic       i_idle,
    input  logic       i_preamble,
    input  pre_sel_t   i_pre_sel,
    input  logic [2:0] i_pre_idx,
    input  logic       i_half,
    input  logic       i_bit,
    output logic       o_line
);

    logic       r_line;
    logic       r_plvl;
    logic       w_lvl;
    logic       w_next;
    logic [7:0] w_pat;

    // Next half-cell: preambles are relative to the level before them, data cells toggle at start and mid-cell for a 1
    always_comb begin
        w_pat = pre_pattern(i_pre_sel);
        w_lvl = (i_pre_idx == 3'd0) ? r_line : r_plvl;
        if (i_preamble) begin
            w_next = w_pat[3'd7 - i_pre_idx] ^ w_lvl;
        end else if (!i_half) begin
            w_next = ~r_line;
        end else begin
            w_next = r_line ^ i_bit;
        end
    end

    // Line register advances only on a tick; idle forces the line low
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_line <= 1'b0;
            r_plvl <= 1'b0;
        end else if (i_tick) begin
            if (i_idle) begin
                r_line <= 1'b0;
            end else begin
                r_line <= w_next;
                if (i_preamble && (i_pre_idx == 3'd0)) begin
                    r_plvl <= r_line;
                end
            end
        end
    end

    assign o_line = r_line;

endmodule

// File: rtl/spdif_transmitter.sv
// rtl/spdif_transmitter.sv - S/PDIF frame builder with one-entry sample buffer; SPDIF_CHSTAT_EN enables channel status
module spdif_transmitter
    import audipus_pkg::*;
#(
    parameter int SAMPLE_W = 24
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 bmc_tick,
    spdif_transmitter_if.slave   smp,
    input  logic [31:0]          chan_status,
    output logic                 spdif_out,
    output logic                 frame_start,
    output logic                 underrun
);

    logic [6:0]          r_hc;
    logic [7:0]          r_frame;
    logic                r_alive;
    logic                r_full;
    logic [SAMPLE_W-1:0] r_buf_l;
    logic [SAMPLE_W-1:0] r_buf_r;
    logic [23:0]         r_aud_l;
    logic [23:0]         r_aud_r;
    logic                r_v;
    logic                r_frame_start;
    logic                r_underrun;

    logic                w_load;
    logic                w_accept;
    logic                w_sub;
    logic [4:0]          w_slot;
    logic                w_half;
    logic                w_pre;
    logic [2:0]          w_pre_idx;
    pre_sel_t            w_pre_sel;
    logic [23:0]         w_aud;
    logic [23:0]         w_buf_l;
    logic [23:0]         w_buf_r;
    logic                w_c;
    logic                w_par;
    logic [31:0]         w_word;
    logic                w_idle;

    assign w_load    = enable & bmc_tick & (r_hc == 7'd0);
    assign w_accept  = smp.sample_valid & smp.sample_ready;
    assign smp.sample_ready = r_alive & enable & ~r_full;

    assign w_sub     = r_hc[6];
    assign w_slot    = r_hc[5:1];
    assign w_half    = r_hc[0];
    assign w_pre     = (w_slot[4:2] == 3'd0);
    assign w_pre_idx = {w_slot[1:0], w_half};
    assign w_pre_sel = w_sub ? PRE_SEL_W : ((r_frame == 8'd0) ? PRE_SEL_B : PRE_SEL_M);
    assign w_idle    = ~enable;

    // Samples are MSB-aligned to slot 27 so narrower widths leave the low slots at 0
    assign w_buf_l   = 24'(r_buf_l) << (24 - SAMPLE_W);
    assign w_buf_r   = 24'(r_buf_r) << (24 - SAMPLE_W);

`ifdef SPDIF_CHSTAT_EN
    logic [31:0] r_cs;

    // Channel status is sampled once per block so a mid-block change cannot tear the 32 bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cs <= 32'd0;
        end else if (w_load && (r_frame == 8'd0)) begin
            r_cs <= chan_status;
        end
    end

    assign w_c = (r_frame < 8'd32) ? r_cs[r_frame[4:0]] : 1'b0;
`else
    logic w_unused_cs;
    assign w_unused_cs = ^chan_status;
    assign w_c = 1'b0;
`endif

    // Slot word of the current subframe: audio LSB at slot 4, then V, U, C and even parity
    assign w_aud  = w_sub ? r_aud_r : r_aud_l;
    assign w_par  = ^{w_aud, r_v, w_c};
    assign w_word = {w_par, w_c, 1'b0, r_v, w_aud, 4'b0000};

    // Half-cell position and block counters; disabling rewinds to frame 0 slot 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hc    <= 7'd0;
            r_frame <= 8'd0;
        end else if (!enable) begin
            r_hc    <= 7'd0;
            r_frame <= 8'd0;
        end else if (bmc_tick) begin
            r_hc <= r_hc + 7'd1;
            if (r_hc == 7'(HALF_PER_FRAME - 1)) begin
                r_frame <= (r_frame == 8'(FRAMES_PER_BLOCK - 1)) ? 8'd0 : r_frame + 8'd1;
            end
        end
    end

    // One-entry buffer; a pair accepted on the load clock is kept for the following frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_alive <= 1'b0;
            r_full  <= 1'b0;
            r_buf_l <= '0;
            r_buf_r <= '0;
        end else begin
            r_alive <= 1'b1;
            if (w_accept) begin
                r_full  <= 1'b1;
                r_buf_l <= smp.sample_l;
                r_buf_r <= smp.sample_r;
            end else if (w_load) begin
                r_full  <= 1'b0;
            end
        end
    end

    // Frame registers load at slot 0; an empty buffer sends silence flagged invalid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_aud_l       <= 24'd0;
            r_aud_r       <= 24'd0;
            r_v           <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_frame_start <= w_load;
            r_underrun    <= w_load & ~r_full;
            if (w_load) begin
                r_aud_l <= r_full ? w_buf_l : 24'd0;
                r_aud_r <= r_full ? w_buf_r : 24'd0;
                r_v     <= ~r_full;
            end
        end
    end

    spdif_bmc_cell u_cell (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_tick     (bmc_tick),
        .i_idle     (w_idle),
        .i_preamble (w_pre),
        .i_pre_sel  (w_pre_sel),
        .i_pre_idx  (w_pre_idx),
        .i_half     (w_half),
        .i_bit      (w_word[w_slot]),
        .o_line     (spdif_out)
    );

    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;

endmodule

// File: doc/spdif_transmitter.md
SPDIF_TRANSMITTER -- requirements
Module: spdif_transmitter

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 24, audio sample width (16..24), MSB-aligned to slot 27; unused low slots are 0.
REQ-002 SHALL have port clk  input  1  system clock; the only clock.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port enable  input  1  transmit enable; when low, the output is idle.
REQ-005 SHALL have port bmc_tick  input  1  single-clk strobe at 128*fs; each strobe advances one half-cell.
REQ-006 SHALL have port sample_l / sample_r  input  SAMPLE_W each  left / right sample pair.
REQ-007 SHALL have port sample_valid  input  1  the sample pair is valid.
REQ-008 SHALL have port sample_ready  output  1  one-entry buffer empty and enable high.
REQ-009 SHALL have port chan_status  input  32  consumer channel-status bits 0..31.
REQ-010 SHALL have port spdif_out  output  1  biphase-mark line output, registered.
REQ-011 SHALL have port frame_start  output  1  one-clk pulse when frame slot 0 begins.
REQ-012 SHALL have port underrun  output  1  one-clk pulse when a frame starts with the buffer empty.

Function
REQ-013 SHALL accept a pair into the one-entry buffer when sample_valid && sample_ready.
REQ-014 SHALL load the buffer into the frame shift registers on the bmc_tick that starts frame slot 0, and mark the buffer empty.
REQ-015 SHALL on underrun send audio 0 with V=1 in both subframes; otherwise V=0.
REQ-016 SHALL not bypass: accept and load in the same clk stores the new pair for the next frame; loading an empty buffer is still an underrun.
REQ-017 SHALL emit frame = left subframe then right subframe, each 32 slots × 2 half-cells; block = 192 frames, counter wraps 191->0.
REQ-018 SHALL use preambles (half-cells, line level 0 before): B=11101000 (left, frame 0), M=11100010 (left, other frames), W=11100100 (right); all inverted when line level is 1.
REQ-019 SHALL send slots 4..27 audio LSB first, 28 V, 29 U=0, 30 C, 31 P, with P giving even parity over slots 4..31.
REQ-020 SHALL biphase-mark encode slots 4..31: toggle at each cell start, and toggle again mid-cell for a 1.
REQ-021 SHALL change spdif_out only on the clk of a bmc_tick; the new half-cell value is visible on the next clk edge.
REQ-022 SHALL hold spdif_out 0, reset frame/slot counters to frame 0 slot 0, and drop sample_ready while enable is low; the buffer is retained.
REQ-023 SHALL start with B half-cell 0 on the first bmc_tick after enable goes high.
REQ-024 SHALL complete the current half-cell and then go idle if enable falls mid-frame.

Reset
REQ-025 SHALL on reset_n low force: spdif_out 0, frame_start 0, underrun 0, sample_ready 0, buffer empty, counters frame 0 slot 0, line level 0.
REQ-026 SHALL after reset release raise sample_ready on the first clk with enable high.

Configuration
REQ-027 SHALL with SPDIF_CHSTAT_EN defined: latch chan_status at the block start; C = bit n for frame n<32, else 0; same C in both subframes.
REQ-028 SHALL with SPDIF_CHSTAT_EN undefined: ignore chan_status and send C=0 always; the port remains present.

Structure
REQ-029 SHALL hold preamble constants, SLOTS_PER_SUB=32, and FRAMES_PER_BLOCK=192 in shared package audipus_pkg.
REQ-030 SHALL place the half-cell BMC/preamble serializer in one sub-module, spdif_bmc_cell (line-level register, slot bit in, preamble select in).

Verification
REQ-031 SHALL cover: reset, enable=1, bmc_tick every clk -> first 8 half-cells 11101000, frame_start one pulse, underrun one pulse.
REQ-032 SHALL cover: sample_l=24'h000001 preloaded -> left slot 4 half-cells 10; left P makes the slot 4..31 ones count even.
REQ-033 SHALL cover: 192 frames with pairs always supplied -> B on frames 0 and 192, M on frames 1..191, W on every right subframe, no underrun.
REQ-034 SHALL cover: SPDIF_CHSTAT_EN, chan_status=32'h00000004 -> C=1 only in frame 2 (both subframes); without the macro, C=0 throughout.
REQ-035 SHALL cover: sample_valid on the same clk as the slot-0 load with the buffer empty -> underrun pulse, V=1, and that pair sent in the next frame.
REQ-036 SHALL cover: reset_n low mid-subframe -> spdif_out 0 asynchronously; after release and enable, transmission restarts with B.
